// File: rtl/data_mem.sv
// rtl/data_mem.sv - RV32 byte/half/word data memory with post-reset clear sweep
// Asynchronous read, byte-lane writes; READY_o stays low until every word has been zeroed.
module data_mem #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ADDR_i,
    input  logic [31:0] WD_i,
    input  logic        WE_i,
    input  logic        RE_i,
    input  logic [2:0]  FUNCT3_i,
    output logic [31:0] RD_o,
    output logic        READY_o,
    output logic        MISALIGN_o,
    output logic        ERR_STICKY_o
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   ptr;
    logic [AW-1:0]   ptr_next;
    logic            err_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [AW-1:0]   widx;
    logic [1:0]      boff;
    logic            run;
    logic            illegal;
    logic            store_en;
    logic [3:0]      be;
    logic [31:0]     wlanes;
    logic [31:0]     rword;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;

    // Upper address bits are deliberately dropped: the space wraps modulo the array size.
    logic            unused_addr_hi;
    assign unused_addr_hi = &{1'b0, ADDR_i[31:AW+2]};

    assign widx = ADDR_i[AW+1:2];
    assign boff = ADDR_i[1:0];
    assign run  = (state == S_RUN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_INIT;
            ptr   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            if (MISALIGN_o) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            S_INIT: begin
                ptr_next = ptr + AW'(1);
                if (ptr == LAST_WORD) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                state_next = S_RUN;
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

    // Unsigned variants only make sense for loads, so a store carrying them is rejected.
    always_comb begin
        illegal = 1'b0;
        case (FUNCT3_i)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = ADDR_i[0];
            3'b010:  illegal = |ADDR_i[1:0];
            3'b100:  illegal = WE_i;
            3'b101:  illegal = ADDR_i[0] | WE_i;
            default: illegal = 1'b1;
        endcase
    end

    assign MISALIGN_o = (WE_i | RE_i) & run & illegal;
    assign store_en   = WE_i & run & ~illegal;

    always_comb begin
        be     = 4'b1111;
        wlanes = WD_i;
        case (FUNCT3_i[1:0])
            2'b00: begin
                be     = 4'b0001 << boff;
                wlanes = {4{WD_i[7:0]}};
            end
            2'b01: begin
                be     = ADDR_i[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{WD_i[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wlanes = WD_i;
            end
        endcase
    end

    // The array itself is not reset; the sweep owns the write port while in INIT.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state == S_INIT) begin
                mem[ptr] <= '0;
            end else if (store_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
                    end
                end
            end
        end
    end

    assign rword = mem[widx];
    assign rhalf = ADDR_i[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        rbyte = rword[7:0];
        case (boff)
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
    end

    always_comb begin
        RD_o = '0;
        if (RE_i && run && !illegal) begin
            case (FUNCT3_i)
                3'b000:  RD_o = {{24{rbyte[7]}}, rbyte};
                3'b001:  RD_o = {{16{rhalf[15]}}, rhalf};
                3'b010:  RD_o = rword;
                3'b100:  RD_o = {24'h0, rbyte};
                3'b101:  RD_o = {16'h0, rhalf};
                default: RD_o = '0;
            endcase
        end
    end

    assign READY_o      = run;
    assign ERR_STICKY_o = err_q;

endmodule

// File: doc/data_mem.md
# data_mem

Word-organised data memory for the single-cycle RV32 core, sitting directly downstream of the ALU: the ALU result is the byte address, and the register-file rs2 value is the store data. It performs RISC-V byte, halfword and word loads and stores, with sign and zero extension, byte-lane write masking and misalignment detection. After every reset it runs a self-clear sweep that zeroes the array, and it holds `READY_o` low during the sweep so the core can stall the PC.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: number of 32-bit words; must be a power of two ≥ 4.
- `AW`, default log2(`DEPTH_WORDS`): word-index width, derived, not overridden.

Ports:
- `clk_i`, input, 1: single clock; all state updates on the rising edge.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `ADDR_i`, input, 32: byte address (ALU result).
- `WD_i`, input, 32: store data (rs2).
- `WE_i`, input, 1: store request.
- `RE_i`, input, 1: load request.
- `FUNCT3_i`, input, 3: access type. 000 = B, 001 = H, 010 = W, 100 = BU (load only), 101 = HU (load only).
- `RD_o`, output, 32: load data, extended; combinational.
- `READY_o`, output, 1: registered; 1 = sweep finished, accesses honoured.
- `MISALIGN_o`, output, 1: combinational; current access is illegal.
- `ERR_STICKY_o`, output, 1: registered; latches any illegal access until reset.

## Operation
- **Word index:** `ADDR_i[AW+1:2]`. Address bits above that are ignored, so the address space wraps modulo 4·`DEPTH_WORDS` bytes.
- **State machine:** two states, INIT and RUN, plus a clear pointer `ptr` of width `AW`.
  - A sampled `rst_i` forces INIT, `ptr` to 0, `READY_o` to 0 and `ERR_STICKY_o` to 0.
  - In INIT, each edge writes 32'h0 to `mem[ptr]` and increments `ptr`. On the edge that writes word `DEPTH_WORDS`-1, the state moves to RUN.
- **INIT behaviour:** `WE_i` and `RE_i` are ignored. `RD_o` is 0 and `MISALIGN_o` is 0.
- **Illegal access:** `MISALIGN_o` = (`WE_i`|`RE_i`) & RUN & illegal. An access is illegal when any of these holds:
  - H/HU with `ADDR_i[0]`=1;
  - W with `ADDR_i[1:0]`≠0;
  - `FUNCT3_i` ∈ {011, 110, 111};
  - a store with `FUNCT3_i` ∈ {100, 101}.
- **Store (RUN, `WE_i`=1, legal):** written at the rising edge.
  - SB: lane `ADDR_i[1:0]` ← `WD_i[7:0]`.
  - SH: lanes {`ADDR_i[1]`,0} and {`ADDR_i[1]`,1} ← `WD_i[15:0]`, little-endian.
  - SW: all four lanes ← `WD_i`.
  - Unselected lanes are unchanged.
- **Illegal store:** no lane is written.
- **Load (RUN, `RE_i`=1, legal):** the selected byte or halfword of the word.
  - B and H are sign-extended from bit 7 or bit 15.
  - BU and HU are zero-extended.
  - W is returned unchanged.
- **`RD_o` is 0 when:** `RE_i`=0, the load is illegal, or the block is in INIT.
- **`ERR_STICKY_o`:** set at any edge where `MISALIGN_o`=1. It is cleared only by reset.
- **Simultaneous `WE_i` and `RE_i` in one cycle:** `RD_o` returns the pre-write contents, and the write takes effect at the edge.
- **Reset priority:** `rst_i` overrides everything. A store in the reset cycle is dropped. Reset during INIT restarts the sweep from `ptr`=0.
- **Array:** one array of `DEPTH_WORDS`×32, with 4 byte-lane write enables. The read port is asynchronous.

## Timing
- **Reset to ready:** `rst_i` high at edge k, low afterwards.
  - Edges k+1 … k+`DEPTH_WORDS` clear words 0 … `DEPTH_WORDS`-1.
  - `READY_o`=1 after edge k+`DEPTH_WORDS`.
  - First honoured access is in the cycle after that edge.
- **Reset values:** `READY_o`=0, `ERR_STICKY_o`=0, `RD_o`=0, `MISALIGN_o`=0.
- **Load latency:** zero cycles; `RD_o` is valid in the same cycle as `ADDR_i`/`RE_i` (single-cycle core).
- **Store latency:** committed at the rising edge of the request cycle. A load in the next cycle observes it.
- **`ERR_STICKY_o` latency:** rises one edge after `MISALIGN_o`.
- **`READY_o`:** changes only at edges; it never glitches combinationally.

## Test plan
1. Reset for 1 cycle with `DEPTH_WORDS`=256 → `READY_o` is 0 for 256 edges and 1 after the 256th. LW at 0x0, 0x3FC and 0x200 → 0x00000000 each.
2. SW 0x12345678 at 0x10, then the following loads:
   - LB at 0x11 → 0x00000056;
   - LBU at 0x13 → 0x00000012;
   - LH at 0x12 → 0x00001234;
   - LW at 0x10 → 0x12345678.
3. SW 0 at 0x20, SB 0x000000FF at 0x21, SH 0xBEEF at 0x22, then the following loads:
   - LW at 0x20 → 0xBEEFFF00;
   - LB at 0x21 → 0xFFFFFFFF;
   - LHU at 0x22 → 0x0000BEEF;
   - LH at 0x22 → 0xFFFFBEEF.
4. SW 0xAAAAAAAA at 0x102 → `MISALIGN_o`=1 in the same cycle. LW at 0x100 still returns its old value, `ERR_STICKY_o`=1 from the next edge, and it stays 1 through later legal accesses until `rst_i`.
5. Wrap-around: SW 0xCAFEF00D at 0x404, then LW at 0x004 → 0xCAFEF00D. Same-cycle WE+RE at 0x8 returns the old word, and the new word is visible in the next cycle.
6. Reset reasserted at edge 100 of the sweep, with a SW driven during INIT → the sweep restarts, `READY_o` rises 256 edges after the second reset, and the address written during INIT reads 0.
